// File: rtl/mem_pkg.sv
// Shared constants and types for the 32x8 memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    typedef logic [DATA_W-1:0] mem_data_t;
    typedef logic [ADDR_W-1:0] mem_addr_t;

endpackage

// File: rtl/mem_array.sv
// Storage: single synchronous write port, registered read port with sync clear.
// Latency: write commits at the sampling edge; read data valid one cycle after re.
// Backpressure: none; every cycle may read or write, rdata holds between reads.
module mem_array #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; contents are not reset, the sweep in the top clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Responder for the 32x8 memory bus: zero-sweep after reset, then single-cycle reads/writes.
// Latency: writes commit at the sampling edge, data_out valid one cycle after a read strobe.
// Backpressure: ready low for 32 cycles after reset; no wait states once ready. Counters behind MEM_RESP_STATS_EN.
module mem_responder #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              collision,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    import mem_pkg::*;

    mem_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic              coll_q;

    logic              sweeping;
    logic              bus_rd;
    logic              bus_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Access decode: bus strobes only count once the sweep has finished.
    always_comb begin
        sweeping  = (state == CLEAR);
        bus_rd    = (state == READY) && read && !write;
        bus_wr    = (state == READY) && write && !read;
        mem_we    = !rst && (sweeping || bus_wr);
        mem_waddr = sweeping ? ptr : addr;
        mem_wdata = sweeping ? '0 : data_in;
    end

    // Sweep FSM: walk ptr over every entry, enter READY on the edge writing the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}}) begin
                state <= READY;
            end
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else if ((state == READY) && read && write) begin
            coll_q <= 1'b1;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (bus_rd),
        .raddr (addr),
        .rdata (data_out)
    );

    assign ready     = (state == READY);
    assign collision = coll_q;

`ifdef MEM_RESP_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (bus_rd && (rd_cnt_q != {CNT_W{1'b1}})) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (bus_wr && (wr_cnt_q != {CNT_W{1'b1}})) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: behavioural model plus directed literal checks.
// Latency: inputs driven just after negedge, outputs compared at negedge.
// Backpressure: waits on ready with a bounded cycle budget.
module tb_mem_responder;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int CW = 16;
`ifdef MEM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          ready;
    logic          collision;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .ready     (ready),
        .collision (collision),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_dout;
    bit            m_valid = 1'b0;
    bit            m_ready;
    bit            m_coll;
    int            m_left;
    int            m_rd;
    int            m_wr;
    int            sat = (1 << CW) - 1;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_left  = 32;
            m_dout  = '0;
            m_coll  = 1'b0;
            m_rd    = 0;
            m_wr    = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
        end else if (m_valid && !m_ready) begin
            m_left = m_left - 1;
            if (m_left == 0) m_ready = 1'b1;
        end else if (m_valid) begin
            if (read && write) begin
                m_coll = 1'b1;
            end else if (write) begin
                m_mem[addr] = data_in;
                if (m_wr < sat) m_wr = m_wr + 1;
            end else if (read) begin
                m_dout = m_mem[addr];
                if (m_rd < sat) m_rd = m_rd + 1;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("ready",     32'(ready),     32'(m_ready));
                chk("data_out",  32'(data_out),  32'(m_dout));
                chk("collision", 32'(collision), 32'(m_coll));
                chk("rd_count",  32'(rd_count),  STATS ? 32'(m_rd) : 32'd0);
                chk("wr_count",  32'(wr_count),  STATS ? 32'(m_wr) : 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_bus(input bit r, input bit w, input int a, input int d);
        @(negedge clk);
        #1;
        read    = r;
        write   = w;
        addr    = AW'(a);
        data_in = DW'(d);
    endtask

    task automatic rst_pulse(input int n);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int clr_at);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (ready === 1'b1) done = 1'b1;
            if (n == clr_at) begin
                #1;
                read  = 1'b0;
                write = 1'b0;
            end
        end
        chk("ready_latency", n, 32);
    endtask

    task automatic rd_lit(input string name, input int a, input int exp);
        set_bus(1'b1, 1'b0, a, 0);
        set_bus(1'b0, 1'b0, 0, 0);
        chk(name, 32'(data_out), exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Power-up reset held 3 cycles, then the whole array reads zero.
        rst_pulse(3);
        wait_ready(0);
        for (int a = 0; a < 32; a++) set_bus(1'b1, 1'b0, a, 0);
        set_bus(1'b0, 1'b0, 0, 0);
        chk("read_all_zero_last", 32'(data_out), 32'h00);

        // Write then immediate read of the same address.
        set_bus(1'b0, 1'b1, 7, 8'hA5);
        set_bus(1'b1, 1'b0, 7, 0);
        set_bus(1'b0, 1'b0, 0, 0);
        chk("wr_rd_a5", 32'(data_out), 32'hA5);
        set_bus(1'b0, 1'b1, 7, 8'h3C);
        rd_lit("wr_rd_3c", 7, 8'h3C);

        // Collision: no access, data_out held, flag sticks.
        set_bus(1'b1, 1'b1, 3, 8'hFF);
        set_bus(1'b0, 1'b0, 0, 0);
        chk("coll_flag", 32'(collision), 1);
        chk("coll_dout_held", 32'(data_out), 32'h3C);
        rd_lit("coll_mem3_unchanged", 3, 8'h00);
        chk("coll_sticky", 32'(collision), 1);

        // Fresh reset, then write data=addr everywhere and read it back-to-back.
        rst_pulse(1);
        wait_ready(0);
        chk("coll_cleared", 32'(collision), 0);
        for (int a = 0; a < 32; a++) set_bus(1'b0, 1'b1, a, a);
        for (int a = 0; a < 32; a++) set_bus(1'b1, 1'b0, a, 0);
        set_bus(1'b0, 1'b0, 0, 0);
        chk("read_all_last", 32'(data_out), 32'd31);
        chk("wr_count_32", 32'(wr_count), STATS ? 32'd32 : 32'd0);
        chk("rd_count_32", 32'(rd_count), STATS ? 32'd32 : 32'd0);

        // Reset in the middle of the sweep restarts it.
        rst_pulse(1);
        repeat (10) @(negedge clk);
        chk("mid_sweep_not_ready", 32'(ready), 0);
        rst_pulse(1);
        wait_ready(0);

        // Reset after a write wipes the entry.
        set_bus(1'b0, 1'b1, 5, 8'h55);
        rd_lit("wr_rd_55", 5, 8'h55);
        rst_pulse(1);
        wait_ready(0);
        chk("post_rst_coll", 32'(collision), 0);
        chk("post_rst_rd_cnt", 32'(rd_count), 0);
        chk("post_rst_wr_cnt", 32'(wr_count), 0);
        rd_lit("mem5_cleared", 5, 8'h00);

        // Strobes during the sweep are ignored.
        @(negedge clk);
        #1;
        write   = 1'b1;
        addr    = 5'd31;
        data_in = 8'h77;
        rst_pulse(1);
        wait_ready(20);
        chk("clear_ign_rd_cnt", 32'(rd_count), 0);
        chk("clear_ign_wr_cnt", 32'(wr_count), 0);
        chk("clear_ign_coll", 32'(collision), 0);
        rd_lit("clear_ign_mem31", 31, 8'h00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
